// File: rtl/ff_div_arbiter.sv
// ff_div_arbiter
//
// Round-robin arbiter and sequencer in front of one shared GF(2^8)
// multiply/divide/inverse unit. The unit has no handshake, so this block
// grants one requester at a time and drives that requester's operands onto
// the unit. It holds them for LATENCY cycles, captures the 18-bit result and
// strobes it back to the requester. A zero divisor is answered straight away
// with resp_err set, and the unit is not used.
//
// Handshake: in IDLE, a set req_valid[i] bit is a request. The grant is a
// one-cycle req_ready[g] pulse in the cycle after the grant edge. The
// requester must drop req_valid, or present new operands, once it has
// sampled req_ready. In WAIT and RESP, req_valid is ignored; a request still
// pending when the block returns to IDLE is arbitrated again. The response is
// a one-cycle resp_valid[g] strobe. resp_data and resp_err are qualified by
// that strobe and hold their value until the next response.
//
// Ports:
//   clock, reset_n           rising-edge clock, asynchronous active-low reset
//   req_valid[NREQ]          per-requester request
//   req_dividend/divisor     8 bits per requester, requester i on [8i+7:8i]
//   req_ready[NREQ]          one-hot acceptance pulse
//   resp_valid[NREQ]         one-hot response strobe
//   resp_data[18], resp_err  result and divide-by-zero flag
//   busy                     high whenever the FSM is not in IDLE
//   div_dividend/div_divisor operands to the shared unit
//   div_result[18]           result from the shared unit
//   dbg_state[2]             current FSM state (0 IDLE, 1 WAIT, 2 RESP)

module ff_div_arbiter #(
  parameter int NREQ    = 4,
  parameter int LATENCY = 8
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [8*NREQ-1:0]   req_dividend,
  input  logic [8*NREQ-1:0]   req_divisor,
  output logic [NREQ-1:0]     req_ready,
  output logic [NREQ-1:0]     resp_valid,
  output logic [17:0]         resp_data,
  output logic                resp_err,
  output logic                busy,
  output logic [7:0]          div_dividend,
  output logic [7:0]          div_divisor,
  input  logic [17:0]         div_result,
  output logic [1:0]          dbg_state
);

  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  // cnt starts at LATENCY-1 on the grant edge. The capture edge is the one
  // where cnt is already 0, which is LATENCY edges after the grant.
  localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);

  logic [1:0]      state;
  logic [GW-1:0]   g;
  logic [GW-1:0]   ptr;
  logic [CW-1:0]   cnt;

  logic            any_req;
  logic [GW-1:0]   pick;
  logic [GW-1:0]   pick_next;
  logic [NREQ-1:0] pick_oh;
  logic [7:0]      pick_dvd;
  logic [7:0]      pick_dvs;

  // Round-robin search: the first set request starting at ptr and wrapping.
  // The sum is one bit wider so the wrap can be done by a single subtract.
  always_comb begin
    logic [GW:0]   sum;
    logic [GW-1:0] idx;
    any_req = 1'b0;
    pick    = '0;
    sum     = '0;
    idx     = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, ptr} + (GW+1)'(k);
      if (sum >= (GW+1)'(NREQ)) begin
        sum = sum - (GW+1)'(NREQ);
      end
      idx = sum[GW-1:0];
      if (!any_req && req_valid[idx]) begin
        any_req = 1'b1;
        pick    = idx;
      end
    end
  end

  // The operands of the picked requester, and its one-hot grant vector.
  always_comb begin
    pick_dvd = '0;
    pick_dvs = '0;
    pick_oh  = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (pick == GW'(k)) begin
        pick_dvd   = req_dividend[8*k +: 8];
        pick_dvs   = req_divisor[8*k +: 8];
        pick_oh[k] = 1'b1;
      end
    end
  end

  assign pick_next = (pick == GW'(NREQ - 1)) ? '0 : pick + 1'b1;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      g            <= '0;
      ptr          <= '0;
      cnt          <= '0;
      div_dividend <= '0;
      div_divisor  <= '0;
      resp_data    <= '0;
      resp_err     <= 1'b0;
      req_ready    <= '0;
    end else begin
      req_ready <= '0;
      case (state)
        S_IDLE: begin
          if (any_req) begin
            g         <= pick;
            ptr       <= pick_next;
            req_ready <= pick_oh;
            if (pick_dvs != 8'h00) begin
              div_dividend <= pick_dvd;
              div_divisor  <= pick_dvs;
              cnt          <= CNT_LOAD;
              state        <= S_WAIT;
            end else begin
              // Division by zero: answer now and leave the unit's operands
              // untouched.
              resp_data <= '0;
              resp_err  <= 1'b1;
              state     <= S_RESP;
            end
          end
        end
        S_WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            resp_data <= div_result;
            resp_err  <= 1'b0;
            state     <= S_RESP;
          end
        end
        S_RESP: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // The response strobe is decoded from the registered state, so it lasts
  // exactly the single RESP cycle.
  always_comb begin
    resp_valid = '0;
    if (state == S_RESP) begin
      resp_valid[g] = 1'b1;
    end
  end

  assign busy      = (state != S_IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_ff_div_arbiter.sv
module tb_ff_div_arbiter;

  localparam int NREQ    = 4;
  localparam int LATENCY = 8;

  // ---------------- clock / reset ----------------
  logic              clock;
  logic              reset_n;
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_dividend;
  logic [8*NREQ-1:0] req_divisor;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   resp_valid;
  logic [17:0]       resp_data;
  logic              resp_err;
  logic              busy;
  logic [7:0]        div_dividend;
  logic [7:0]        div_divisor;
  logic [17:0]       div_result;
  logic [1:0]        dbg_state;
  int                cyc;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  // Stub unit: the result simply concatenates the operands.
  assign div_result = {2'b00, div_dividend, div_divisor};

  ff_div_arbiter #(.NREQ(NREQ), .LATENCY(LATENCY)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_dividend (req_dividend),
    .req_divisor  (req_divisor),
    .req_ready    (req_ready),
    .resp_valid   (resp_valid),
    .resp_data    (resp_data),
    .resp_err     (resp_err),
    .busy         (busy),
    .div_dividend (div_dividend),
    .div_divisor  (div_divisor),
    .div_result   (div_result),
    .dbg_state    (dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [3:0]  gnt_q[$];
  logic [22:0] exp_q[$];
  int          n_pass;
  int          n_total;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [22:0] rsp(input logic [3:0] oh, input logic err, input logic [17:0] d);
    return {oh, err, d};
  endfunction

  // Monitor: compares every grant and every response against the queues.
  always @(negedge clock) begin
    logic [3:0]  eg;
    logic [22:0] er;
    if (req_ready != '0) begin
      if (gnt_q.size() == 0) chk("unexpected_grant", 32'(req_ready), 32'h0);
      else begin
        eg = gnt_q.pop_front();
        chk("grant", 32'(req_ready), 32'(eg));
      end
    end
    if (resp_valid != '0) begin
      if (exp_q.size() == 0) chk("unexpected_resp", 32'(resp_valid), 32'h0);
      else begin
        er = exp_q.pop_front();
        chk("resp", 32'({resp_valid, resp_err, resp_data}), 32'(er));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_ops(input int i, input logic [7:0] a, input logic [7:0] b);
    req_dividend[8*i +: 8] = a;
    req_divisor[8*i +: 8]  = b;
  endtask

  task automatic wait_ready(output logic [3:0] r, output int c);
    int n;
    n = 0;
    @(negedge clock);
    while (req_ready == '0 && n < 100) begin
      @(negedge clock);
      n++;
    end
    r = req_ready;
    c = cyc;
    if (req_ready == '0) chk("ready_timeout", 32'h0, 32'h1);
  endtask

  task automatic wait_resp(output int c);
    int n;
    n = 0;
    @(negedge clock);
    while (resp_valid == '0 && n < 100) begin
      @(negedge clock);
      n++;
    end
    c = cyc;
    if (resp_valid == '0) chk("resp_timeout", 32'h0, 32'h1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [3:0] r;
    int         c;
    int         cr;
    int         prev;

    n_pass = 0; n_total = 0; cyc = 0;
    reset_n = 1'b0; req_valid = '0; req_dividend = '0; req_divisor = '0;
    repeat (3) @(negedge clock);

    // Reset state
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_resp_valid", 32'(resp_valid), 32'h0);
    chk("rst_resp_data", 32'(resp_data), 32'h0);
    chk("rst_resp_err", 32'(resp_err), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_div", 32'({div_dividend, div_divisor}), 32'h0);
    chk("rst_state", 32'(dbg_state), 32'h0);
    reset_n = 1'b1;

    // Single request on requester 2
    @(negedge clock);
    set_ops(2, 8'h0B, 8'h06);
    gnt_q.push_back(4'b0100);
    exp_q.push_back(rsp(4'b0100, 1'b0, 18'h00B06));
    req_valid = 4'b0100;
    wait_ready(r, c);
    req_valid = '0;
    chk("single_busy", 32'(busy), 32'h1);
    chk("single_state_wait", 32'(dbg_state), 32'h1);
    chk("single_div", 32'({div_dividend, div_divisor}), 32'h0B06);
    wait_resp(cr);
    chk("single_latency", 32'(cr - c), 32'(LATENCY));

    // Divide by zero on requester 1
    @(negedge clock);
    set_ops(1, 8'h53, 8'h00);
    gnt_q.push_back(4'b0010);
    exp_q.push_back(rsp(4'b0010, 1'b1, 18'h0));
    req_valid = 4'b0010;
    wait_ready(r, c);
    req_valid = '0;
    chk("dz_same_cycle", 32'(resp_valid), 32'h2);
    chk("dz_div_hold", 32'({div_dividend, div_divisor}), 32'h0B06);

    // Contention: all four valid out of reset, grants 0,1,2,3 ten cycles apart
    @(negedge clock);
    reset_n = 1'b0;
    set_ops(0, 8'h11, 8'h22);
    set_ops(1, 8'h33, 8'h44);
    set_ops(2, 8'h55, 8'h66);
    set_ops(3, 8'h77, 8'h88);
    req_valid = 4'b1111;
    gnt_q.push_back(4'b0001); exp_q.push_back(rsp(4'b0001, 1'b0, 18'h01122));
    gnt_q.push_back(4'b0010); exp_q.push_back(rsp(4'b0010, 1'b0, 18'h03344));
    gnt_q.push_back(4'b0100); exp_q.push_back(rsp(4'b0100, 1'b0, 18'h05566));
    gnt_q.push_back(4'b1000); exp_q.push_back(rsp(4'b1000, 1'b0, 18'h07788));
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    prev = 0;
    for (int k = 0; k < 4; k++) begin
      wait_ready(r, c);
      req_valid = req_valid & ~r;
      if (k > 0) chk("contention_interval", 32'(c - prev), 32'(LATENCY + 2));
      prev = c;
    end
    wait_resp(cr);

    // Fairness: requesters 0 and 3 held valid, grants alternate 0,3,0,3
    @(negedge clock);
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) begin
        gnt_q.push_back(4'b0001); exp_q.push_back(rsp(4'b0001, 1'b0, 18'h01122));
      end else begin
        gnt_q.push_back(4'b1000); exp_q.push_back(rsp(4'b1000, 1'b0, 18'h07788));
      end
    end
    req_valid = 4'b1001;
    for (int k = 0; k < 4; k++) begin
      wait_ready(r, c);
      if (k == 3) req_valid = '0;
      if (k > 0) chk("fair_interval", 32'(c - prev), 32'(LATENCY + 2));
      prev = c;
    end
    wait_resp(cr);

    // Reset four cycles into WAIT: no response, then requester 1 wins
    @(negedge clock);
    set_ops(2, 8'h0B, 8'h06);
    gnt_q.push_back(4'b0100);
    req_valid = 4'b0100;
    wait_ready(r, c);
    req_valid = '0;
    repeat (4) @(negedge clock);
    chk("midwait_busy", 32'(busy), 32'h1);
    reset_n = 1'b0;
    set_ops(1, 8'h5A, 8'h3C);
    req_valid = 4'b0010;
    #1;
    chk("arst_req_ready", 32'(req_ready), 32'h0);
    chk("arst_resp_valid", 32'(resp_valid), 32'h0);
    chk("arst_resp_data", 32'(resp_data), 32'h0);
    chk("arst_resp_err", 32'(resp_err), 32'h0);
    chk("arst_busy", 32'(busy), 32'h0);
    chk("arst_div", 32'({div_dividend, div_divisor}), 32'h0);
    repeat (3) @(negedge clock);
    gnt_q.push_back(4'b0010);
    exp_q.push_back(rsp(4'b0010, 1'b0, 18'h05A3C));
    reset_n = 1'b1;
    wait_ready(r, c);
    req_valid = '0;
    wait_resp(cr);
    chk("post_reset_latency", 32'(cr - c), 32'(LATENCY));

    // Operand stability: requester changes its operands during WAIT
    @(negedge clock);
    set_ops(0, 8'h21, 8'h07);
    gnt_q.push_back(4'b0001);
    exp_q.push_back(rsp(4'b0001, 1'b0, 18'h02107));
    req_valid = 4'b0001;
    wait_ready(r, c);
    req_valid = '0;
    set_ops(0, 8'hFF, 8'h01);
    repeat (3) @(negedge clock);
    chk("stable_div", 32'({div_dividend, div_divisor}), 32'h2107);
    wait_resp(cr);
    chk("stable_resp_err", 32'(resp_err), 32'h0);

    repeat (15) @(negedge clock);
    chk("grant_q_empty", 32'(gnt_q.size()), 32'h0);
    chk("resp_q_empty", 32'(exp_q.size()), 32'h0);
    chk("idle_at_end", 32'(busy), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
